// File: rtl/eprisc_bus_arbiter.sv
// eprisc_bus_arbiter: round-robin peripheral bus arbiter; one transaction at a time,
// with wait states and a timeout abort.
module eprisc_bus_arbiter #(
    parameter int REQUESTERS = 4,
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [REQUESTERS-1:0]            req,
    input  logic [REQUESTERS-1:0]            req_write,
    input  logic [REQUESTERS*ADDR_WIDTH-1:0] req_addr,
    input  logic [REQUESTERS*DATA_WIDTH-1:0] req_data,
    output logic [REQUESTERS-1:0]            grant,
    output logic [REQUESTERS-1:0]            ack,
    output logic                             error,
    output logic [31:0]                      read_data,
    output logic [ADDR_WIDTH-1:0]            bus_address,
    output logic [DATA_WIDTH-1:0]            bus_data,
    output logic                             bus_write,
    output logic                             bus_enable,
    input  logic [31:0]                      bus_miso,
    input  logic                             bus_ready
);
    localparam int IW = $clog2(REQUESTERS);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
    state_t          state;
    logic [IW-1:0]   last;
    logic [IW-1:0]   pick;
    logic [CW-1:0]   count;
    logic            wr;
    int              j;
    // Scan from farthest to nearest so the nearest requester after last wins.
    always_comb begin
        pick = last;
        j    = 0;
        for (int i = REQUESTERS; i >= 1; i--) begin
            j = (int'(last) + i) % REQUESTERS;
            if (req[j]) pick = IW'(j);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last        <= IW'(REQUESTERS - 1);
            count       <= '0;
            wr          <= 1'b0;
            grant       <= '0;
            ack         <= '0;
            error       <= 1'b0;
            read_data   <= '0;
            bus_address <= '0;
            bus_data    <= '0;
            bus_write   <= 1'b0;
            bus_enable  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (|req) begin
                    state       <= ACCESS;
                    last        <= pick;
                    grant       <= REQUESTERS'(1) << pick;
                    wr          <= req_write[pick];
                    bus_write   <= req_write[pick];
                    bus_enable  <= 1'b1;
                    bus_address <= req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
                    bus_data    <= req_data[pick*DATA_WIDTH +: DATA_WIDTH];
                    count       <= '0;
                end
                ACCESS: if (bus_ready || count == CW'(TIMEOUT - 1)) begin
                    state      <= ACK;
                    ack        <= grant;
                    error      <= !bus_ready;
                    read_data  <= (bus_ready && !wr) ? bus_miso : '0;
                    bus_enable <= 1'b0;
                    bus_write  <= 1'b0;
                end else begin
                    count <= count + 1'b1;
                end
                ACK: begin
                    state       <= IDLE;
                    ack         <= '0;
                    error       <= 1'b0;
                    grant       <= '0;
                    bus_address <= '0;
                    bus_data    <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eprisc_bus_arbiter.sv
// tb_eprisc_bus_arbiter: directed stimulus, per-cycle comparison against a transaction-level
// model, plus literal expectations for latency, timeout and read data.
module tb_eprisc_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [3:0]  req_write = '0;
    logic [59:0] req_addr = '0;
    logic [63:0] req_data = '0;
    logic [3:0]  grant, ack;
    logic        error, bus_write, bus_enable;
    logic [31:0] read_data;
    logic [14:0] bus_address;
    logic [15:0] bus_data;
    logic [31:0] bus_miso = '0;
    logic        bus_ready = 1'b0;
    int checks = 0;
    int errors = 0;

    eprisc_bus_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .req_write(req_write), .req_addr(req_addr),
        .req_data(req_data), .grant(grant), .ack(ack), .error(error), .read_data(read_data),
        .bus_address(bus_address), .bus_data(bus_data), .bus_write(bus_write),
        .bus_enable(bus_enable), .bus_miso(bus_miso), .bus_ready(bus_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 access, 2 ack; m_cnt counts access cycles spent so far.
    int          m_phase, m_last, m_win, m_cnt;
    logic        m_wr, m_err;
    logic [14:0] m_addr;
    logic [15:0] m_data;
    logic [31:0] m_rd;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_last = 3; m_win = 0; m_cnt = 0;
            m_wr = 0; m_err = 0; m_addr = 0; m_data = 0; m_rd = 0;
        end else if (m_phase == 0) begin
            for (int k = 1; k <= 4 && m_phase == 0; k++) begin
                if (req[(m_last + k) % 4]) begin
                    m_win   = (m_last + k) % 4;
                    m_last  = m_win;
                    m_wr    = req_write[m_win];
                    m_addr  = req_addr[m_win*15 +: 15];
                    m_data  = req_data[m_win*16 +: 16];
                    m_cnt   = 1;
                    m_phase = 1;
                end
            end
        end else if (m_phase == 1) begin
            if (bus_ready) begin
                m_rd = m_wr ? 32'h0 : bus_miso; m_err = 0; m_phase = 2;
            end else if (m_cnt == 16) begin
                m_rd = 0; m_err = 1; m_phase = 2;
            end else m_cnt++;
        end else begin
            m_phase = 0; m_err = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("grant", 32'(grant), m_phase != 0 ? 32'(1 << m_win) : 32'h0);
            chk("ack", 32'(ack), m_phase == 2 ? 32'(1 << m_win) : 32'h0);
            chk("error", 32'(error), 32'(m_phase == 2 && m_err));
            chk("read_data", read_data, m_rd);
            chk("bus_enable", 32'(bus_enable), 32'(m_phase == 1));
            chk("bus_write", 32'(bus_write), 32'(m_phase == 1 && m_wr));
            chk("bus_address", 32'(bus_address), m_phase != 0 ? 32'(m_addr) : 32'h0);
            chk("bus_data", 32'(bus_data), m_phase != 0 ? 32'(m_data) : 32'h0);
        end
    end

    // Per-transaction observations for the literal checks.
    int cyc = 0;
    int en_run = 0, wr_run = 0, last_en = 0, last_wr = 0;
    logic [3:0]  last_ack;
    logic        last_err;
    logic [31:0] last_rd;
    int ack_q[$];
    int ack_cyc[$];
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (rst) begin
            en_run = 0; wr_run = 0;
        end else begin
            if (bus_enable) en_run++;
            if (bus_write) wr_run++;
            if (ack != 0) begin
                last_en = en_run; last_wr = wr_run; en_run = 0; wr_run = 0;
                last_ack = ack; last_err = error; last_rd = read_data;
                for (int k = 0; k < 4; k++) if (ack[k]) ack_q.push_back(k);
                ack_cyc.push_back(cyc);
            end
        end
    end

    task automatic set_m(input int k, input logic w, input logic [14:0] a, input logic [15:0] d);
        req_write[k]      = w;
        req_addr[k*15 +: 15] = a;
        req_data[k*16 +: 16] = d;
    endtask

    task automatic wait_ack(input int max);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack === 4'b0 && n < max);
        chk("ack_seen", 32'(ack != 4'b0), 32'h1);
        #1;
    endtask

    initial begin
        int nack;
        repeat (2) @(negedge clk);
        rst = 0;
        // Single read with immediate ready
        set_m(0, 0, 15'h0300, 16'h0);
        bus_ready = 1; bus_miso = 32'h12345678; req = 4'b0001;
        wait_ack(10);
        req = 0;
        chk("t1_en_cycles", last_en, 1);
        chk("t1_ack", 32'(last_ack), 32'h1);
        chk("t1_rd", last_rd, 32'h12345678);
        chk("t1_err", 32'(last_err), 0);
        // All four requesting: rotation from a fresh reset
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        ack_q.delete(); ack_cyc.delete();
        for (int k = 0; k < 4; k++) set_m(k, 0, 15'(16'h0010 + k), 16'h0);
        bus_miso = 32'h0BADF00D; req = 4'hF;
        for (int i = 0; i < 6; i++) wait_ack(10);
        req = 0;
        chk("t2_n_acks", ack_q.size(), 6);
        for (int i = 0; i < 6 && i < ack_q.size(); i++) chk("t2_order", ack_q[i], i % 4);
        for (int i = 1; i < 6 && i < ack_cyc.size(); i++) chk("t2_period", ack_cyc[i] - ack_cyc[i-1], 3);
        // Write with three wait states
        @(negedge clk);
        bus_ready = 0; set_m(2, 1, 15'h0105, 16'hBEEF); req = 4'b0100;
        repeat (4) @(negedge clk);
        bus_ready = 1;
        wait_ack(5);
        req = 0;
        chk("t3_en_cycles", last_en, 4);
        chk("t3_wr_cycles", last_wr, 4);
        chk("t3_ack", 32'(last_ack), 32'h4);
        chk("t3_rd", last_rd, 0);
        // Ready on the last allowed access cycle beats the timeout
        @(negedge clk);
        set_m(1, 0, 15'h0042, 16'h0); bus_miso = 32'hA5A5A5A5; bus_ready = 0; req = 4'b0010;
        repeat (16) @(negedge clk);
        bus_ready = 1;
        wait_ack(5);
        req = 0;
        chk("t5_en_cycles", last_en, 16);
        chk("t5_err", 32'(last_err), 0);
        chk("t5_rd", last_rd, 32'hA5A5A5A5);
        // No ready at all: timeout abort clears read data
        @(negedge clk);
        bus_ready = 0; req = 4'b0010;
        wait_ack(40);
        req = 0;
        chk("t4_en_cycles", last_en, 16);
        chk("t4_ack", 32'(last_ack), 32'h2);
        chk("t4_err", 32'(last_err), 1);
        chk("t4_rd", last_rd, 0);
        // Async reset mid-access, then req0 beats req3
        @(negedge clk);
        set_m(0, 1, 15'h0077, 16'h1234); set_m(3, 0, 15'h0333, 16'h0); req = 4'b0001;
        repeat (2) @(negedge clk);
        chk("t6_pre_en", 32'(bus_enable), 1);
        chk("t6_pre_wr", 32'(bus_write), 1);
        nack = ack_q.size();
        #2 rst = 1;
        #1;
        chk("t6_rst_en", 32'(bus_enable), 0);
        chk("t6_rst_wr", 32'(bus_write), 0);
        chk("t6_rst_grant", 32'(grant), 0);
        chk("t6_rst_addr", 32'(bus_address), 0);
        @(negedge clk);
        req = 4'b1001; bus_ready = 1;
        @(negedge clk);
        chk("t6_no_ack", ack_q.size(), nack);
        rst = 0;
        wait_ack(10);
        chk("t6_first", 32'(last_ack), 32'h1);
        req = 4'b1000;
        wait_ack(10);
        chk("t6_second", 32'(last_ack), 32'h8);
        req = 0;
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
